// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Grant counters in mem_arbiter are built only when MEM_ARB_GRANT_COUNT_EN is defined.
package mem_arb_pkg;

    localparam int LAT_W          = 4;
    localparam int DEFAULT_ADDR_W = 16;
    localparam int DATA_W         = 32;
    localparam int GCNT_W         = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT_M0 = 1'b0;
    localparam port_id_t PORT_M1 = 1'b1;

    function automatic logic [GCNT_W-1:0] sat_inc(input logic [GCNT_W-1:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Round-robin decision for two requesters; remembers the last granted port.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_req0,
    input  logic     i_req1,
    input  logic     i_update,
    output port_id_t o_grant,
    output logic     o_any
);

    port_id_t r_last_grant;
    port_id_t w_grant;

    // Grant decision: a lone requester wins, a tie goes to the port not served last
    always_comb begin
        w_grant = PORT_M0;
        if (i_req0 && i_req1) begin
            w_grant = ~r_last_grant;
        end else if (i_req1) begin
            w_grant = PORT_M1;
        end else begin
            w_grant = PORT_M0;
        end
    end

    // Last-grant register, preset to m1 so m0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= PORT_M1;
        end else if (i_update) begin
            r_last_grant <= w_grant;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    assign o_grant = w_grant;
    assign o_any   = i_req0 | i_req1;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port data memory (m0 = loader, m1 = CPU).
// Define MEM_ARB_GRANT_COUNT_EN to build the saturating per-port grant counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic [31:0]       m0_rdata,
    output logic              m0_done,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic [31:0]       m1_rdata,
    output logic              m1_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1
);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

    arb_state_t        r_state, w_state_nx;
    logic [LAT_W-1:0]  r_cnt, w_cnt_nx;
    port_id_t          r_gnt, w_gnt_nx;
    logic              r_we, w_we_nx;

    logic              r_mem_en, w_mem_en_nx;
    logic              r_mem_we, w_mem_we_nx;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nx;
    logic [31:0]       r_mem_wdata, w_mem_wdata_nx;
    logic              r_m0_done, w_m0_done_nx;
    logic              r_m1_done, w_m1_done_nx;
    logic [31:0]       r_m0_rdata, w_m0_rdata_nx;
    logic [31:0]       r_m1_rdata, w_m1_rdata_nx;

    port_id_t          w_rr_gnt;
    logic              w_any_req;
    logic              w_rr_upd;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;

    mem_arb_rr u_rr (
        .clk      (clk),
        .rst_n    (reset),
        .i_req0   (m0_req),
        .i_req1   (m1_req),
        .i_update (w_rr_upd),
        .o_grant  (w_rr_gnt),
        .o_any    (w_any_req)
    );

    assign w_sel_we    = (w_rr_gnt == PORT_M1) ? m1_we    : m0_we;
    assign w_sel_addr  = (w_rr_gnt == PORT_M1) ? m1_addr  : m0_addr;
    assign w_sel_wdata = (w_rr_gnt == PORT_M1) ? m1_wdata : m0_wdata;

    // Next state and next values of every registered output
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_gnt_nx       = r_gnt;
        w_we_nx        = r_we;
        w_rr_upd       = 1'b0;
        w_mem_en_nx    = 1'b0;
        w_mem_we_nx    = 1'b0;
        w_mem_addr_nx  = {ADDR_W{1'b0}};
        w_mem_wdata_nx = 32'd0;
        w_m0_done_nx   = 1'b0;
        w_m1_done_nx   = 1'b0;
        w_m0_rdata_nx  = r_m0_rdata;
        w_m1_rdata_nx  = r_m1_rdata;
        case (r_state)
            IDLE: begin
                w_m0_rdata_nx = 32'd0;
                w_m1_rdata_nx = 32'd0;
                if (w_any_req) begin
                    w_state_nx     = ISSUE;
                    w_rr_upd       = 1'b1;
                    w_gnt_nx       = w_rr_gnt;
                    w_we_nx        = w_sel_we;
                    w_mem_en_nx    = 1'b1;
                    w_mem_we_nx    = w_sel_we;
                    w_mem_addr_nx  = w_sel_addr;
                    w_mem_wdata_nx = w_sel_wdata;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            ISSUE: begin
                if (r_we) begin
                    w_state_nx   = DONE;
                    w_m0_done_nx = (r_gnt == PORT_M0);
                    w_m1_done_nx = (r_gnt == PORT_M1);
                end else begin
                    w_state_nx = WAIT;
                    w_cnt_nx   = LAT_INIT;
                end
            end
            WAIT: begin
                // Memory data is valid exactly in the cycle the counter reaches zero
                if (r_cnt == 4'd0) begin
                    w_state_nx = DONE;
                    if (r_gnt == PORT_M1) begin
                        w_m1_done_nx  = 1'b1;
                        w_m1_rdata_nx = mem_rdata;
                    end else begin
                        w_m0_done_nx  = 1'b1;
                        w_m0_rdata_nx = mem_rdata;
                    end
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            DONE: begin
                w_state_nx    = IDLE;
                w_m0_rdata_nx = 32'd0;
                w_m1_rdata_nx = 32'd0;
            end
            default: begin
                w_state_nx    = IDLE;
                w_m0_rdata_nx = 32'd0;
                w_m1_rdata_nx = 32'd0;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_gnt       <= PORT_M0;
            r_we        <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= 32'd0;
            r_m0_done   <= 1'b0;
            r_m1_done   <= 1'b0;
            r_m0_rdata  <= 32'd0;
            r_m1_rdata  <= 32'd0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_gnt       <= w_gnt_nx;
            r_we        <= w_we_nx;
            r_mem_en    <= w_mem_en_nx;
            r_mem_we    <= w_mem_we_nx;
            r_mem_addr  <= w_mem_addr_nx;
            r_mem_wdata <= w_mem_wdata_nx;
            r_m0_done   <= w_m0_done_nx;
            r_m1_done   <= w_m1_done_nx;
            r_m0_rdata  <= w_m0_rdata_nx;
            r_m1_rdata  <= w_m1_rdata_nx;
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign m0_done   = r_m0_done;
    assign m1_done   = r_m1_done;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;

`ifdef MEM_ARB_GRANT_COUNT_EN
    logic [GCNT_W-1:0] r_gcnt0;
    logic [GCNT_W-1:0] r_gcnt1;

    // Saturating grant counters, bumped on each entry to ISSUE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gcnt0 <= 16'd0;
            r_gcnt1 <= 16'd0;
        end else if (w_rr_upd) begin
            if (w_rr_gnt == PORT_M1) begin
                r_gcnt1 <= sat_inc(r_gcnt1);
            end else begin
                r_gcnt0 <= sat_inc(r_gcnt0);
            end
        end else begin
            r_gcnt0 <= r_gcnt0;
            r_gcnt1 <= r_gcnt1;
        end
    end

    assign grant_cnt0 = r_gcnt0;
    assign grant_cnt1 = r_gcnt1;
`else
    assign grant_cnt0 = 16'd0;
    assign grant_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with MEM_LAT=1 and MEM_LAT=4 instances.
module tb_mem_arbiter;

`ifdef MEM_ARB_GRANT_COUNT_EN
    localparam logic [15:0] EXP_GCNT = 16'd5;
`else
    localparam logic [15:0] EXP_GCNT = 16'd0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        m0_req, m0_we, m1_req, m1_we, m0_done, m1_done;
    logic [15:0] m0_addr, m1_addr, mem_addr, grant_cnt0, grant_cnt1;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
    logic        mem_en, mem_we;

    logic        m0_req_4, m0_we_4, m1_req_4, m1_we_4, m0_done_4, m1_done_4;
    logic [15:0] m0_addr_4, m1_addr_4, mem_addr_4, grant_cnt0_4, grant_cnt1_4;
    logic [31:0] m0_wdata_4, m1_wdata_4, m0_rdata_4, m1_rdata_4, mem_wdata_4, mem_rdata_4;
    logic        mem_en_4, mem_we_4;

    int n_checks = 0;
    int n_err    = 0;

    mem_arbiter #(.ADDR_W(16), .MEM_LAT(1)) u_dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_done(m0_done),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_done(m1_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    mem_arbiter #(.ADDR_W(16), .MEM_LAT(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .m0_req(m0_req_4), .m0_we(m0_we_4), .m0_addr(m0_addr_4), .m0_wdata(m0_wdata_4),
        .m0_rdata(m0_rdata_4), .m0_done(m0_done_4),
        .m1_req(m1_req_4), .m1_we(m1_we_4), .m1_addr(m1_addr_4), .m1_wdata(m1_wdata_4),
        .m1_rdata(m1_rdata_4), .m1_done(m1_done_4),
        .mem_en(mem_en_4), .mem_we(mem_we_4), .mem_addr(mem_addr_4), .mem_wdata(mem_wdata_4),
        .mem_rdata(mem_rdata_4), .grant_cnt0(grant_cnt0_4), .grant_cnt1(grant_cnt1_4)
    );

    // One-cycle-latency memory behind u_dut
    logic [31:0] mem1 [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem1[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem1[mem_addr[7:0]];
        end
    end

    // Four-cycle-latency memory behind u_dut4
    logic [31:0] mem4 [0:255];
    logic [31:0] pipe4 [0:3];
    always @(posedge clk) begin
        if (mem_en_4 && mem_we_4) mem4[mem_addr_4[7:0]] <= mem_wdata_4;
        pipe4[0] <= mem4[mem_addr_4[7:0]];
        pipe4[1] <= pipe4[0];
        pipe4[2] <= pipe4[1];
        pipe4[3] <= pipe4[2];
    end
    assign mem_rdata_4 = pipe4[3];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Step n cycles on u_dut (sampling at negedge) and record first mem_en / done cycles.
    int          en_first, en_cnt, d0_first, d1_first, d0_cnt, d1_cnt;
    logic [31:0] r0, r1;
    task automatic run_cycles(input int n);
        en_first = -1; en_cnt = 0; d0_first = -1; d1_first = -1; d0_cnt = 0; d1_cnt = 0;
        r0 = 32'd0; r1 = 32'd0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (mem_en) begin
                en_cnt++;
                if (en_first < 0) en_first = k;
            end
            if (m0_done) begin
                d0_cnt++;
                if (d0_first < 0) begin d0_first = k; r0 = m0_rdata; end
            end
            if (m1_done) begin
                d1_cnt++;
                if (d1_first < 0) begin d1_first = k; r1 = m1_rdata; end
            end
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          found;
        int          dcyc;
        logic [31:0] rd;
        reset = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 16'd0; m0_wdata = 32'd0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 16'd0; m1_wdata = 32'd0;
        m0_req_4 = 1'b0; m0_we_4 = 1'b0; m0_addr_4 = 16'd0; m0_wdata_4 = 32'd0;
        m1_req_4 = 1'b0; m1_we_4 = 1'b0; m1_addr_4 = 16'd0; m1_wdata_4 = 32'd0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ctl", {28'd0, m0_done, m1_done, mem_en, mem_we}, 32'd0);
        check("rst_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        check("rst_gcnt", {grant_cnt0, grant_cnt1}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // m1 write 7 to addr 3, then read it back
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'd3; m1_wdata = 32'h7;
        run_cycles(2);
        check("wr_en_cyc", en_first, 32'd1);
        check("wr_done_cyc", d1_first, 32'd2);
        m1_req = 1'b0; m1_we = 1'b0;
        @(negedge clk);
        m1_req = 1'b1;
        run_cycles(3);
        check("rd_en_cyc", en_first, 32'd1);
        check("rd_done_cyc", d1_first, 32'd3);
        check("rd_data", r1, 32'h7);
        check("rd_m0_quiet", d0_cnt, 32'd0);
        m1_req = 1'b0;
        @(negedge clk);

        // m0 write 0x55 to addr 5
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'd5; m0_wdata = 32'h55;
        run_cycles(2);
        check("m0_wr_done_cyc", d0_first, 32'd2);
        m0_req = 1'b0; m0_we = 1'b0;
        @(negedge clk);

        // Tie after reset: m0 first, then m1
        pulse_reset();
        m0_req = 1'b1; m0_addr = 16'd5;
        m1_req = 1'b1; m1_addr = 16'd3;
        run_cycles(3);
        check("tie_m0_done_cyc", d0_first, 32'd3);
        check("tie_m0_data", r0, 32'h55);
        check("tie_m1_quiet", d1_cnt, 32'd0);
        check("tie_en_cnt0", en_cnt, 32'd1);
        m0_req = 1'b0;
        run_cycles(4);
        check("tie_m1_gap", d1_first, 32'd4);
        check("tie_m1_en_cyc", en_first, 32'd2);
        check("tie_en_cnt1", en_cnt, 32'd1);
        check("tie_m1_data", r1, 32'h7);
        m1_req = 1'b0;
        @(negedge clk);

        // Sustained contention: 10 reads must alternate m0, m1, ...
        pulse_reset();
        m0_req = 1'b1; m1_req = 1'b1;
        for (int g = 0; g < 10; g++) begin
            found = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (m0_done || m1_done) begin
                    found = 1;
                    break;
                end
            end
            check($sformatf("rr_found_%0d", g), found, 32'd1);
            check($sformatf("rr_port_%0d", g), {30'd0, m1_done, m0_done},
                  (g % 2 == 0) ? 32'd1 : 32'd2);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        check("gcnt0", {16'd0, grant_cnt0}, {16'd0, EXP_GCNT});
        check("gcnt1", {16'd0, grant_cnt1}, {16'd0, EXP_GCNT});

        // MEM_LAT=4: write DEADBEEF to 0x00FF, read it back via m1
        m0_req_4 = 1'b1; m0_we_4 = 1'b1; m0_addr_4 = 16'h00FF; m0_wdata_4 = 32'hDEADBEEF;
        dcyc = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (m0_done_4) begin dcyc = k; break; end
        end
        check("lat4_wr_done_cyc", dcyc, 32'd2);
        m0_req_4 = 1'b0; m0_we_4 = 1'b0;
        @(negedge clk);
        m1_req_4 = 1'b1; m1_we_4 = 1'b0; m1_addr_4 = 16'h00FF;
        dcyc = -1; rd = 32'd0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (m1_done_4) begin dcyc = k; rd = m1_rdata_4; break; end
        end
        check("lat4_rd_done_cyc", dcyc, 32'd6);
        check("lat4_rd_data", rd, 32'hDEADBEEF);
        m1_req_4 = 1'b0;
        @(negedge clk);

        // Reset during WAIT abandons the read
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'd3;
        run_cycles(2);
        reset = 1'b0;
        #1;
        check("midrst_ctl", {28'd0, m0_done, m1_done, mem_en, mem_we}, 32'd0);
        check("midrst_addr", {16'd0, mem_addr}, 32'd0);
        check("midrst_rdata", m0_rdata | m1_rdata, 32'd0);
        m1_req = 1'b0;
        run_cycles(3);
        check("midrst_no_done_in", d1_cnt, 32'd0);
        reset = 1'b1;
        run_cycles(3);
        check("midrst_no_done_out", d1_cnt + d0_cnt, 32'd0);
        m1_req = 1'b1;
        run_cycles(3);
        check("postrst_done_cyc", d1_first, 32'd3);
        check("postrst_data", r1, 32'h7);
        m1_req = 1'b0;
        @(negedge clk);

        // m0 drops req during WAIT; access completes, then pending m1 is served
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'd5;
        run_cycles(2);
        m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'd3;
        run_cycles(5);
        check("drop_m0_done_cyc", d0_first, 32'd1);
        check("drop_m0_once", d0_cnt, 32'd1);
        check("drop_m0_data", r0, 32'h55);
        check("drop_m1_done_cyc", d1_first, 32'd5);
        check("drop_m1_data", r1, 32'h7);
        m1_req = 1'b0;
        run_cycles(2);
        check("drop_quiet", d0_cnt + d1_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
